dual_path_capture: RTL and testbench
====================================

# dual_path_capture

Two-stage capture block that registers a WIDTH-bit input along two parallel paths on the same clock. In the immediate path, both registers load the current input on each edge. In the pipelined path, the second register loads the previous value of the first. The block is a reference pair for comparing same-edge copy and one-cycle-delayed shift behaviour. It sits between a free-running stimulus source and any observer of the four register outputs.

## Interface
- WIDTH, 4, bit width of the input and of every output register
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  data sampled on every rising clk edge
- b1  output  WIDTH  immediate path, first register
- c1  output  WIDTH  immediate path, second register
- b2  output  WIDTH  pipelined path, first register
- c2  output  WIDTH  pipelined path, second register

## Operation
- All four outputs come straight from flip-flops. No combinational path runs from a to any output.
- Immediate path, on each rising clk edge with rst_n high:
  - b1 ← a
  - c1 ← a (the same sampled value)
  - b1 == c1 holds at all times after the first edge.
- Pipelined path, on each rising clk edge with rst_n high:
  - b2 ← a
  - c2 ← value b2 held before this edge
  - The path is a 2-deep shift register.
- Reset:
  - rst_n low forces b1, c1, b2, c2 to 0 immediately, without waiting for clk.
  - All four outputs hold 0 while rst_n is low.
- Reset release:
  - The first rising edge with rst_n high loads normally.
  - On that edge c2 loads 0, the reset value of b2.
- No enable. Every edge outside reset updates all four registers.
- Widths are unsigned and copied bit-for-bit. No arithmetic, truncation or extension.

## Timing
- b1, c1, b2: latency 1 cycle. The value of a at edge N is visible after edge N.
- c2: latency 2 cycles. The value of a at edge N appears after edge N+1.
- a is sampled at the rising edge and must meet setup/hold. A change of a exactly at a falling edge has no effect until the next rising edge.
- Reset asserted mid-stream:
  - Both paths clear at once, including any in-flight value in b2.
  - After release, c2 shows 0 for one cycle before showing new data.
- Reset deasserted coincident with a rising edge: that edge is ignored. Loading starts at the following edge.
- Constant input: after 2 edges all four outputs equal a.

## Test plan
- Reset then stimulus. clk period 100 ns with first rise at 50 ns. Pulse rst_n low then release before 50 ns. Drive a = 3, 7, F, A, 2 at 0, 100, 200, 300, 400 ns.
  - After the edges at 50/150/250/350/450 ns: b1 = c1 = b2 = 3/7/F/A/2.
  - At the same edges: c2 = 0/3/7/F/A.
- Async reset mid-run. Pull rst_n low at 275 ns, between edges.
  - All outputs read 0 at 276 ns, with no clk edge in between.
  - Release at 320 ns with a = A. The 350 ns edge gives b1 = c1 = b2 = A and c2 = 0.
- Constant input. Hold a = 5 for 3 edges: all four outputs equal 5 from the second edge on.
- Width check. Set WIDTH = 8 and drive a = 8'hA5 then 8'h3C.
  - After the 2nd edge: c1 = 3C and c2 = A5.
  - No bits are lost.
- Glitch immunity. Toggle a several times between rising edges. Outputs change only at rising edges and reflect only the value present at the edge.

Source files
------------

// File: rtl/dual_path_capture_if.sv
// rtl/dual_path_capture_if.sv - data input and four register outputs of dual_path_capture
interface dual_path_capture_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b1;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-1:0] b2;
  logic [WIDTH-1:0] c2;

  modport master (output a, input b1, c1, b2, c2);
  modport slave  (input a, output b1, c1, b2, c2);
endinterface

// File: rtl/dual_path_capture.sv
// rtl/dual_path_capture.sv - same-edge copy pair and 2-deep shift pair sampling one input
module dual_path_capture #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dual_path_capture_if.slave bus
);

  logic [WIDTH-1:0] b1_q, b1_d;
  logic [WIDTH-1:0] c1_q, c1_d;
  logic [WIDTH-1:0] b2_q, b2_d;
  logic [WIDTH-1:0] c2_q, c2_d;

  // c2 takes b2's pre-edge value, so a reset-cleared b2 feeds 0 into c2 on the first edge.
  always_comb begin
    b1_d = bus.a;
    c1_d = bus.a;
    b2_d = bus.a;
    c2_d = b2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_q <= '0;
      c1_q <= '0;
      b2_q <= '0;
      c2_q <= '0;
    end else begin
      b1_q <= b1_d;
      c1_q <= c1_d;
      b2_q <= b2_d;
      c2_q <= c2_d;
    end
  end

  assign bus.b1 = b1_q;
  assign bus.c1 = c1_q;
  assign bus.b2 = b2_q;
  assign bus.c2 = c2_q;

endmodule

// File: tb/tb_dual_path_capture.sv
// tb/tb_dual_path_capture.sv - randomized and directed checks of dual_path_capture at WIDTH 4 and 8
module tb_dual_path_capture;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // history of values accepted since the last reset, oldest first
  int hist4[$];
  int hist8[$];

  dual_path_capture_if #(.WIDTH(4)) bus4 ();
  dual_path_capture_if #(.WIDTH(8)) bus8 ();

  dual_path_capture #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  dual_path_capture #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // value accepted 'back' edges ago (0 = most recent); 0 if none since reset
  function automatic logic [31:0] hist_at(input int which, input int back);
    int sz;
    sz = (which == 0) ? hist4.size() : hist8.size();
    if (back >= sz) return 32'd0;
    return (which == 0) ? hist4[sz-1-back] : hist8[sz-1-back];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_b1_w4"}, 32'(bus4.b1), hist_at(0, 0));
    check({tag, "_c1_w4"}, 32'(bus4.c1), hist_at(0, 0));
    check({tag, "_b2_w4"}, 32'(bus4.b2), hist_at(0, 0));
    check({tag, "_c2_w4"}, 32'(bus4.c2), hist_at(0, 1));
    check({tag, "_b1_w8"}, 32'(bus8.b1), hist_at(1, 0));
    check({tag, "_c1_w8"}, 32'(bus8.c1), hist_at(1, 0));
    check({tag, "_b2_w8"}, 32'(bus8.b2), hist_at(1, 0));
    check({tag, "_c2_w8"}, 32'(bus8.c2), hist_at(1, 1));
  endtask

  task automatic step(input string tag, input logic [3:0] v4, input logic [7:0] v8);
    bus4.a = v4;
    bus8.a = v8;
    @(posedge clk);
    if (rst_n) begin
      hist4.push_back(int'(v4));
      hist8.push_back(int'(v8));
    end
    #1;
    check_all(tag);
  endtask

  // called 1 time unit after an edge; asserts and releases reset before the next edge
  task automatic reset_pulse(input string tag);
    #20;
    rst_n = 1'b0;
    #1;
    check({tag, "_b1"}, 32'(bus4.b1), 32'd0);
    check({tag, "_c1"}, 32'(bus4.c1), 32'd0);
    check({tag, "_b2"}, 32'(bus4.b2), 32'd0);
    check({tag, "_c2"}, 32'(bus4.c2), 32'd0);
    check({tag, "_c2_w8"}, 32'(bus8.c2), 32'd0);
    check({tag, "_b2_w8"}, 32'(bus8.b2), 32'd0);
    hist4.delete();
    hist8.delete();
    #20;
    rst_n = 1'b1;
  endtask

  // a wiggles between edges, including exactly at the falling edge; outputs must not move
  task automatic glitch_step(input logic [3:0] v4, input logic [7:0] v8);
    bus4.a = 4'($urandom);
    bus8.a = 8'($urandom);
    #20;
    check_all("glitch_mid");
    bus4.a = 4'($urandom);
    bus8.a = 8'($urandom);
    @(negedge clk);
    bus4.a = 4'($urandom);
    bus8.a = 8'($urandom);
    #1;
    check_all("glitch_fall");
    step("glitch_edge", v4, v8);
  endtask

  initial begin
    logic [3:0] dir_a [5];
    logic [3:0] dir_c2[5];
    n_checks = 0;
    n_pass   = 0;
    dir_a  = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
    dir_c2 = '{4'h0, 4'h3, 4'h7, 4'hF, 4'hA};

    rst_n  = 1'b0;
    bus4.a = 4'h3;
    bus8.a = 8'h33;
    #1;
    check("reset_b1", 32'(bus4.b1), 32'd0);
    check("reset_c1", 32'(bus4.c1), 32'd0);
    check("reset_b2", 32'(bus4.b2), 32'd0);
    check("reset_c2", 32'(bus4.c2), 32'd0);
    check("reset_c2_w8", 32'(bus8.c2), 32'd0);
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step("dir", dir_a[i], {dir_a[i], dir_a[i]});
      check("dir_b1_tbl", 32'(bus4.b1), 32'(dir_a[i]));
      check("dir_c2_tbl", 32'(bus4.c2), 32'(dir_c2[i]));
    end

    reset_pulse("midrst");
    step("after_rst", 4'hA, 8'hAA);
    check("after_rst_b1", 32'(bus4.b1), 32'hA);
    check("after_rst_c2", 32'(bus4.c2), 32'h0);
    step("after_rst2", 4'h6, 8'h66);
    check("after_rst2_c2", 32'(bus4.c2), 32'hA);

    for (int i = 0; i < 3; i++) begin
      step("const", 4'h5, 8'h55);
      if (i >= 1) begin
        check("const_b1", 32'(bus4.b1), 32'h5);
        check("const_c1", 32'(bus4.c1), 32'h5);
        check("const_b2", 32'(bus4.b2), 32'h5);
        check("const_c2", 32'(bus4.c2), 32'h5);
      end
    end

    step("w8_1", 4'h1, 8'hA5);
    step("w8_2", 4'h2, 8'h3C);
    check("w8_c1", 32'(bus8.c1), 32'h3C);
    check("w8_c2", 32'(bus8.c2), 32'hA5);

    for (int i = 0; i < 4; i++)
      glitch_step(4'($urandom), 8'($urandom));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) reset_pulse("rnd_rst");
      step("rnd", 4'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
